// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave -- I2C target with a small register file fronting an MRAM port.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   sda (inout), scl      I2C bus; sda is only ever pulled low or released
//   myReg0..myReg3        MRAM command and 21-bit address registers
//   data_lb, data_ub      MRAM data bytes; driven only while write_en is set
//   myReg6, myReg7        general-purpose read/write registers
//   myReg8..myReg15       read-only status inputs
//   chip_en, read_en, write_en, lb_en, ub_en  MRAM strobes decoded from myReg0
module i2c_slave #(
  parameter logic [6:0] I2C_ADDRESS = 7'h3C,
  parameter int         DEB_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        sda,
  input  logic       scl,
  output logic [7:0] myReg0,
  output logic [7:0] myReg1,
  output logic [7:0] myReg2,
  output logic [7:0] myReg3,
  inout  wire  [7:0] data_lb,
  inout  wire  [7:0] data_ub,
  output logic [7:0] myReg6,
  output logic [7:0] myReg7,
  input  logic [7:0] myReg8,
  input  logic [7:0] myReg9,
  input  logic [7:0] myReg10,
  input  logic [7:0] myReg11,
  input  logic [7:0] myReg12,
  input  logic [7:0] myReg13,
  input  logic [7:0] myReg14,
  input  logic [7:0] myReg15,
  output logic       chip_en,
  output logic       read_en,
  output logic       write_en,
  output logic       lb_en,
  output logic       ub_en
);

  localparam int CNT_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, RX_REGADDR, RX_DATA, ACK_RX, TX_DATA, RX_MACK
  } state_t;

  // Bit 0 = scl, bit 1 = sda.
  logic [1:0] line_raw;
  logic [1:0] line_filt;
  assign line_raw = {sda, scl};

  // Two-flop synchroniser followed by a filter that only flips its output
  // after DEB_LEN consecutive samples disagree with the current level.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic [1:0]       sync_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= 2'b11;
          cnt_reg  <= '0;
          filt_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], line_raw[gi]};
          if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEB_LEN - 1)) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
      assign line_filt[gi] = filt_reg;
    end
  endgenerate

  logic scl_f, sda_f, scl_prev_reg, sda_prev_reg;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = line_filt[0];
  assign sda_f     = line_filt[1];
  assign scl_rise  = scl_f & ~scl_prev_reg;
  assign scl_fall  = ~scl_f & scl_prev_reg;
  assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] ptr_reg, ptr_next;
  logic       rw_reg, rw_next;
  logic       mack_reg, mack_next;
  logic       sda_low_reg, sda_low_next;
  logic       wr_en;
  logic [7:0] rx_byte, rd_data;
  logic [7:0] wdata_lb, wdata_ub, rd_lb, rd_ub;

  assign rx_byte = {rx_shift_reg[6:0], sda_f};

  always_comb begin
    case (ptr_reg)
      8'd0:    rd_data = myReg0;
      8'd1:    rd_data = myReg1;
      8'd2:    rd_data = myReg2;
      8'd3:    rd_data = myReg3;
      8'd4:    rd_data = rd_lb;
      8'd5:    rd_data = rd_ub;
      8'd6:    rd_data = myReg6;
      8'd7:    rd_data = myReg7;
      8'd8:    rd_data = myReg8;
      8'd9:    rd_data = myReg9;
      8'd10:   rd_data = myReg10;
      8'd11:   rd_data = myReg11;
      8'd12:   rd_data = myReg12;
      8'd13:   rd_data = myReg13;
      8'd14:   rd_data = myReg14;
      8'd15:   rd_data = myReg15;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      ptr_reg      <= '0;
      rw_reg       <= 1'b0;
      mack_reg     <= 1'b0;
      sda_low_reg  <= 1'b0;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_shift_reg <= rx_shift_next;
      tx_shift_reg <= tx_shift_next;
      ptr_reg      <= ptr_next;
      rw_reg       <= rw_next;
      mack_reg     <= mack_next;
      sda_low_reg  <= sda_low_next;
      scl_prev_reg <= scl_f;
      sda_prev_reg <= sda_f;
    end
  end

  // ACK states count scl falls in bit_cnt: the first fall (end of the 8th
  // bit) pulls sda low, the second (end of the ACK clock) releases it.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_shift_next = rx_shift_reg;
    tx_shift_next = tx_shift_reg;
    ptr_next      = ptr_reg;
    rw_next       = rw_reg;
    mack_next     = mack_reg;
    sda_low_next  = sda_low_reg;
    wr_en         = 1'b0;
    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_low_next = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      sda_low_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        ADDR, RX_REGADDR, RX_DATA: begin
          if (scl_rise) begin
            rx_shift_next = rx_byte;
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_next = '0;
              if (state_reg == ADDR) begin
                if (rx_byte[7:1] == I2C_ADDRESS) begin
                  rw_next    = rx_byte[0];
                  state_next = ACK_ADDR;
                end else begin
                  state_next = IDLE;
                end
              end else if (state_reg == RX_REGADDR) begin
                ptr_next   = rx_byte;
                state_next = ACK_RX;
              end else begin
                wr_en      = 1'b1;
                ptr_next   = ptr_reg + 8'd1;
                state_next = ACK_RX;
              end
            end
          end
        end
        ACK_ADDR, ACK_RX: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd0) begin
              sda_low_next = 1'b1;
              bit_cnt_next = 4'd1;
            end else begin
              bit_cnt_next = '0;
              if (state_reg == ACK_ADDR && rw_reg) begin
                tx_shift_next = rd_data;
                sda_low_next  = ~rd_data[7];
                ptr_next      = ptr_reg + 8'd1;
                state_next    = TX_DATA;
              end else begin
                sda_low_next = 1'b0;
                state_next   = (state_reg == ACK_ADDR) ? RX_REGADDR : RX_DATA;
              end
            end
          end
        end
        TX_DATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_low_next = 1'b0;
              bit_cnt_next = '0;
              state_next   = RX_MACK;
            end else begin
              tx_shift_next = {tx_shift_reg[6:0], 1'b0};
              sda_low_next  = ~tx_shift_reg[6];
            end
          end
        end
        RX_MACK: begin
          if (scl_rise) begin
            mack_next    = ~sda_f;
            bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next = '0;
            if (mack_reg) begin
              tx_shift_next = rd_data;
              sda_low_next  = ~rd_data[7];
              ptr_next      = ptr_reg + 8'd1;
              state_next    = TX_DATA;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Register file; pointers 8 and above accept the write but keep nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      myReg0   <= '0;
      myReg1   <= '0;
      myReg2   <= '0;
      myReg3   <= '0;
      wdata_lb <= '0;
      wdata_ub <= '0;
      myReg6   <= '0;
      myReg7   <= '0;
      rd_lb    <= '0;
      rd_ub    <= '0;
    end else begin
      if (wr_en) begin
        case (ptr_reg)
          8'd0:    myReg0   <= rx_byte;
          8'd1:    myReg1   <= rx_byte;
          8'd2:    myReg2   <= rx_byte;
          8'd3:    myReg3   <= rx_byte;
          8'd4:    wdata_lb <= rx_byte;
          8'd5:    wdata_ub <= rx_byte;
          8'd6:    myReg6   <= rx_byte;
          8'd7:    myReg7   <= rx_byte;
          default: ;
        endcase
      end
      if (read_en) begin
        rd_lb <= data_lb;
        rd_ub <= data_ub;
      end
    end
  end

  assign chip_en  = myReg0[0];
  assign write_en = myReg0[0] & myReg0[1];
  assign read_en  = myReg0[0] & ~myReg0[1];
  assign lb_en    = myReg0[2];
  assign ub_en    = myReg0[3];

  assign sda     = sda_low_reg ? 1'b0 : 1'bz;
  assign data_lb = write_en ? wdata_lb : 8'hzz;
  assign data_ub = write_en ? wdata_ub : 8'hzz;

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// tb_i2c_slave -- directed bus-master bench for i2c_slave.
module tb_i2c_slave;

  localparam int Q = 100;  // quarter bit: sda set-up after scl falls
  localparam int H = 200;  // scl high time

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic m_sda_low = 1'b0;
  logic bus_drv = 1'b0;
  logic [7:0] stat [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  wire       sda;
  wire [7:0] data_lb, data_ub;
  logic [7:0] r0, r1, r2, r3, r6, r7;
  logic chip_en, read_en, write_en, lb_en, ub_en;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign data_lb = bus_drv ? 8'h55 : 8'hzz;
  assign data_ub = bus_drv ? 8'h55 : 8'hzz;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk(clk), .rst(rst), .sda(sda), .scl(scl_m),
    .myReg0(r0), .myReg1(r1), .myReg2(r2), .myReg3(r3),
    .data_lb(data_lb), .data_ub(data_ub),
    .myReg6(r6), .myReg7(r7),
    .myReg8(stat[0]), .myReg9(stat[1]), .myReg10(stat[2]), .myReg11(stat[3]),
    .myReg12(stat[4]), .myReg13(stat[5]), .myReg14(stat[6]), .myReg15(stat[7]),
    .chip_en(chip_en), .read_en(read_en), .write_en(write_en),
    .lb_en(lb_en), .ub_en(ub_en)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    #(2*Q); scl_m = 1'b1;
    #Q;     m_sda_low = 1'b1;
    #Q;     scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; m_sda_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i];
      #Q; scl_m = 1'b1;
      #H; scl_m = 1'b0;
      #Q;
    end
    m_sda_low = 1'b0;
    #Q; scl_m = 1'b1;
    #(H/2); ack = (sda == 1'b0);
    #(H/2); scl_m = 1'b0;
    #Q;
  endtask

  task automatic read_byte(input logic do_ack, output logic [7:0] b);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_m = 1'b1;
      #(H/2); b[i] = sda;
      #(H/2); scl_m = 1'b0;
      #Q;
    end
    m_sda_low = do_ack;
    #Q; scl_m = 1'b1;
    #H; scl_m = 1'b0;
    #Q; m_sda_low = 1'b0;
  endtask

  task automatic wr_regs(input string tag, input logic [7:0] ptr, input int n,
                         input logic [7:0] d [4]);
    logic ack;
    i2c_start();
    write_byte(8'h78, ack); check({tag, "_addr_ack"}, ack, 1);
    write_byte(ptr, ack);   check({tag, "_ptr_ack"}, ack, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack); check({tag, "_data_ack"}, ack, 1);
    end
    i2c_stop();
    $display("[txn] %s: write ptr=%02h bytes=%0d", tag, ptr, n);
  endtask

  task automatic rd_regs(input string tag, input bit set_ptr, input logic [7:0] ptr,
                         input int n, input logic [7:0] exp [8]);
    logic ack;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'h78, ack); check({tag, "_waddr_ack"}, ack, 1);
      write_byte(ptr, ack);   check({tag, "_ptr_ack"}, ack, 1);
      i2c_start();
    end
    write_byte(8'h79, ack); check({tag, "_raddr_ack"}, ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, b);
      check({tag, "_rdata"}, b, exp[i]);
    end
    i2c_stop();
    $display("[txn] %s: read bytes=%0d", tag, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack;
    #22;
    check("rst_reg0", r0, 8'h00);
    check("rst_chip_en", chip_en, 0);
    check("rst_sda", sda, 1);
    rst = 1'b0;
    #100;

    // Command and address registers.
    wr_regs("t1", 8'h00, 4, '{8'h03, 8'h10, 8'h32, 8'h01});
    check("t1_reg0", r0, 8'h03);
    check("t1_reg1", r1, 8'h10);
    check("t1_reg2", r2, 8'h32);
    check("t1_reg3", r3, 8'h01);
    check("t1_strobes", {chip_en, write_en, read_en, lb_en, ub_en}, 5'b11000);

    // Write data bytes and byte enables; slave drives the data buses.
    wr_regs("t2a", 8'h04, 2, '{8'hA5, 8'h5A, 8'h00, 8'h00});
    wr_regs("t2b", 8'h00, 1, '{8'h0F, 8'h00, 8'h00, 8'h00});
    #100;
    check("t2_data_lb", data_lb, 8'hA5);
    check("t2_data_ub", data_ub, 8'h5A);
    check("t2_strobes", {write_en, lb_en, ub_en}, 3'b111);

    // GP registers, auto-increment into a discarded pointer, read back.
    wr_regs("t2c", 8'h06, 3, '{8'hC3, 8'h3C, 8'h99, 8'h00});
    check("t2c_reg6", r6, 8'hC3);
    check("t2c_reg7", r7, 8'h3C);
    rd_regs("t2d", 1'b1, 8'h06, 2, '{8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

    // Read command: capture the bus the bench drives, read it back.
    wr_regs("t3a", 8'h00, 1, '{8'h0D, 8'h00, 8'h00, 8'h00});
    check("t3_strobes", {chip_en, write_en, read_en, lb_en, ub_en}, 5'b10111);
    bus_drv = 1'b1;
    #100;
    check("t3_bus_lb", data_lb, 8'h55);
    rd_regs("t3b", 1'b1, 8'h04, 2, '{8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

    // Status registers, then one past the end of the map.
    rd_regs("t4a", 1'b1, 8'h08, 8, '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0});
    rd_regs("t4b", 1'b0, 8'h00, 1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

    // Wrong address: NACKed and ignored; a good transfer still works.
    i2c_start();
    write_byte(8'hA0, ack); check("t5_bad_addr_nack", ack, 0);
    write_byte(8'h00, ack); check("t5_bad_ptr_nack", ack, 0);
    write_byte(8'hFF, ack); check("t5_bad_data_nack", ack, 0);
    i2c_stop();
    $display("[txn] t5a: write to address 0x50");
    check("t5_reg0_kept", r0, 8'h0D);
    wr_regs("t5b", 8'h07, 1, '{8'h81, 8'h00, 8'h00, 8'h00});
    check("t5_reg7", r7, 8'h81);

    // Reset in the middle of a data byte.
    bus_drv = 1'b0;
    i2c_start();
    write_byte(8'h78, ack); check("t6_addr_ack", ack, 1);
    write_byte(8'h01, ack); check("t6_ptr_ack", ack, 1);
    for (int i = 7; i >= 4; i--) begin
      m_sda_low = ~(i[0]);
      #Q; scl_m = 1'b1;
      #H; scl_m = 1'b0;
      #Q;
    end
    m_sda_low = 1'b0;
    rst = 1'b1;
    #50;
    rst = 1'b0;
    #20;
    $display("[txn] t6a: reset during write of reg1");
    check("t6_regs", {r0, r1, r2, r3, r6, r7}, 48'h0);
    check("t6_strobes", {chip_en, write_en, read_en, lb_en, ub_en}, 5'b00000);
    check("t6_sda", sda, 1);
    i2c_stop();
    wr_regs("t6b", 8'h01, 1, '{8'hE7, 8'h00, 8'h00, 8'h00});
    check("t6_reg1", r1, 8'hE7);
    check("t6_reg0", r0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
